// File: rtl/pipeline_control_ldst_arb_pkg.sv
// Shared types for the load/store port arbiter: FSM states, requester
// indices, access-size and direction encodings.
package pipeline_control_ldst_arb_pkg;

  localparam int RQ_NUM = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    RQ_HUNDLER = 2'd0,
    RQ_SYSREG  = 2'd1,
    RQ_LSU     = 2'd2
  } rq_idx_e;

  typedef enum logic [1:0] {
    ORDER_BYTE = 2'b00,
    ORDER_HALF = 2'b01,
    ORDER_WORD = 2'b10,
    ORDER_NONE = 2'b11
  } order_e;

  typedef enum logic {
    RW_READ  = 1'b0,
    RW_WRITE = 1'b1
  } rw_e;

  // Fixed priority: the lowest-index requester wins.
  function automatic logic [1:0] func_lowest_use(input logic [2:0] use_bits);
    if (use_bits[0]) begin
      return RQ_HUNDLER;
    end else if (use_bits[1]) begin
      return RQ_SYSREG;
    end else begin
      return RQ_LSU;
    end
  endfunction

endpackage

// File: rtl/pipeline_control_ldst_arb_outstd.sv
// Saturating up/down counter of accesses accepted by the load/store unit
// but not yet answered.
module pipeline_control_ldst_arb_outstd
  import pipeline_control_ldst_arb_pkg::*;
#(
  parameter int P_MAX = 3
) (
  input  logic       iCLOCK,
  input  logic       inRESET,
  input  logic       iRESET_SYNC,
  input  logic       iINC,
  input  logic       iDEC,
  output logic [1:0] oCOUNT,
  output logic       oFULL,
  output logic       oEMPTY,
  output logic       oUNDERFLOW
);

  localparam logic [1:0] L_MAX = 2'(P_MAX);

  logic [1:0] b_count;
  logic       inc_en;
  logic       dec_en;

  assign oFULL      = (b_count == L_MAX);
  assign oEMPTY     = (b_count == 2'd0);
  assign oUNDERFLOW = iDEC && oEMPTY;
  assign oCOUNT     = b_count;

  // Saturate at both ends so a stray strobe can never wrap the count.
  assign inc_en = iINC && !oFULL;
  assign dec_en = iDEC && !oEMPTY;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      b_count <= 2'd0;
    end else if (iRESET_SYNC) begin
      b_count <= 2'd0;
    end else if (inc_en && !dec_en) begin
      b_count <= b_count + 2'd1;
    end else if (dec_en && !inc_en) begin
      b_count <= b_count - 2'd1;
    end
  end

endmodule

// File: rtl/pipeline_control_ldst_arbiter.sv
// Shares the core load/store port between the IDT reader, the sysreg
// save/restore sequencer and the LSU, one ownership burst at a time.
module pipeline_control_ldst_arbiter
  import pipeline_control_ldst_arb_pkg::*;
#(
  parameter int P_MAX_OUTSTANDING = 3
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iRESET_SYNC,
  input  logic [2:0]  iRQ_USE,
  input  logic [2:0]  iRQ_REQ,
  input  logic [5:0]  iRQ_ORDER,
  input  logic [2:0]  iRQ_RW,
  input  logic [95:0] iRQ_ADDR,
  input  logic [95:0] iRQ_DATA,
  output logic [2:0]  oRQ_BUSY,
  output logic [2:0]  oRQ_VALID,
  output logic [31:0] oRQ_DATA,
  output logic        oLDST_USE,
  output logic        oLDST_REQ,
  input  logic        iLDST_BUSY,
  output logic [1:0]  oLDST_ORDER,
  output logic        oLDST_RW,
  output logic [31:0] oLDST_ADDR,
  output logic [31:0] oLDST_DATA,
  input  logic        iLDST_REQ,
  input  logic [31:0] iLDST_DATA,
  output logic        oPROTOCOL_ERR
);

  arb_state_e b_state;
  arb_state_e next_state;
  logic [1:0] b_owner;
  logic [1:0] next_owner;
  logic       b_prot_err;

  logic        own_use;
  logic        own_req;
  logic        own_rw;
  logic [1:0]  own_order;
  logic [31:0] own_addr;
  logic [31:0] own_data;

  logic [1:0] outstd_count;
  logic       outstd_full;
  logic       outstd_empty;
  logic       outstd_underflow;

  logic ldst_req;
  logic accept;
  logic resp_fwd;
  logic drained;

  // Owner slice select.
  always_comb begin
    own_use   = 1'b0;
    own_req   = 1'b0;
    own_rw    = RW_READ;
    own_order = ORDER_BYTE;
    own_addr  = 32'd0;
    own_data  = 32'd0;
    for (int i = 0; i < RQ_NUM; i++) begin
      if (b_owner == 2'(i)) begin
        own_use   = iRQ_USE[i];
        own_req   = iRQ_REQ[i];
        own_rw    = iRQ_RW[i];
        own_order = iRQ_ORDER[2*i +: 2];
        own_addr  = iRQ_ADDR[32*i +: 32];
        own_data  = iRQ_DATA[32*i +: 32];
      end
    end
  end

  assign ldst_req = (b_state == OWNED) && own_req && !outstd_full;
  assign accept   = ldst_req && !iLDST_BUSY;
  assign resp_fwd = iLDST_REQ && !outstd_empty;
  // True when the count will be zero after this edge.
  assign drained  = !accept && (outstd_empty || ((outstd_count == 2'd1) && resp_fwd));

  pipeline_control_ldst_arb_outstd #(
    .P_MAX (P_MAX_OUTSTANDING)
  ) u_outstd (
    .iCLOCK      (iCLOCK),
    .inRESET     (inRESET),
    .iRESET_SYNC (iRESET_SYNC),
    .iINC        (accept),
    .iDEC        (iLDST_REQ),
    .oCOUNT      (outstd_count),
    .oFULL       (outstd_full),
    .oEMPTY      (outstd_empty),
    .oUNDERFLOW  (outstd_underflow)
  );

  always_comb begin
    next_state = b_state;
    next_owner = b_owner;
    case (b_state)
      IDLE: begin
        if (|iRQ_USE) begin
          next_owner = func_lowest_use(iRQ_USE);
          next_state = OWNED;
        end
      end
      OWNED: begin
        if (!own_use) begin
          next_state = drained ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        if (drained) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    oLDST_USE   = (b_state != IDLE);
    oLDST_REQ   = ldst_req;
    oLDST_ORDER = ORDER_BYTE;
    oLDST_RW    = RW_READ;
    oLDST_ADDR  = 32'd0;
    oLDST_DATA  = 32'd0;
    if (b_state == OWNED) begin
      oLDST_ORDER = own_order;
      oLDST_RW    = own_rw;
      oLDST_ADDR  = own_addr;
      oLDST_DATA  = own_data;
    end
  end

  // Only the owner in OWNED may see BUSY low; responses go to the owner
  // in OWNED and DRAIN alike.
  always_comb begin
    oRQ_BUSY  = 3'b111;
    oRQ_VALID = 3'b000;
    for (int i = 0; i < RQ_NUM; i++) begin
      if (b_owner == 2'(i)) begin
        oRQ_BUSY[i]  = (b_state != OWNED) || iLDST_BUSY || outstd_full;
        oRQ_VALID[i] = (b_state != IDLE) && resp_fwd;
      end
    end
    oRQ_DATA = (|oRQ_VALID) ? iLDST_DATA : 32'd0;
  end

  assign oPROTOCOL_ERR = b_prot_err;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      b_state    <= IDLE;
      b_owner    <= 2'd0;
      b_prot_err <= 1'b0;
    end else if (iRESET_SYNC) begin
      b_state    <= IDLE;
      b_owner    <= 2'd0;
      b_prot_err <= 1'b0;
    end else begin
      b_state <= next_state;
      b_owner <= next_owner;
      if (outstd_underflow) begin
        b_prot_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_control_ldst_arbiter.sv
// Bench for the load/store port arbiter: directed bursts with literal
// expectations, then random traffic against an ownership/count model.
module tb_pipeline_control_ldst_arbiter;

  localparam int MAXO = 3;

  logic        iCLOCK = 1'b0;
  logic        inRESET;
  logic        iRESET_SYNC;
  logic [2:0]  iRQ_USE;
  logic [2:0]  iRQ_REQ;
  logic [5:0]  iRQ_ORDER;
  logic [2:0]  iRQ_RW;
  logic [95:0] iRQ_ADDR;
  logic [95:0] iRQ_DATA;
  logic [2:0]  oRQ_BUSY;
  logic [2:0]  oRQ_VALID;
  logic [31:0] oRQ_DATA;
  logic        oLDST_USE;
  logic        oLDST_REQ;
  logic        iLDST_BUSY;
  logic [1:0]  oLDST_ORDER;
  logic        oLDST_RW;
  logic [31:0] oLDST_ADDR;
  logic [31:0] oLDST_DATA;
  logic        iLDST_REQ;
  logic [31:0] iLDST_DATA;
  logic        oPROTOCOL_ERR;

  logic [1:0]  ord [3];
  logic [31:0] adr [3];
  logic [31:0] wd  [3];

  assign iRQ_ORDER = {ord[2], ord[1], ord[0]};
  assign iRQ_ADDR  = {adr[2], adr[1], adr[0]};
  assign iRQ_DATA  = {wd[2], wd[1], wd[0]};

  always #5 iCLOCK = ~iCLOCK;

  pipeline_control_ldst_arbiter #(.P_MAX_OUTSTANDING(MAXO)) dut (
    .iCLOCK        (iCLOCK),
    .inRESET       (inRESET),
    .iRESET_SYNC   (iRESET_SYNC),
    .iRQ_USE       (iRQ_USE),
    .iRQ_REQ       (iRQ_REQ),
    .iRQ_ORDER     (iRQ_ORDER),
    .iRQ_RW        (iRQ_RW),
    .iRQ_ADDR      (iRQ_ADDR),
    .iRQ_DATA      (iRQ_DATA),
    .oRQ_BUSY      (oRQ_BUSY),
    .oRQ_VALID     (oRQ_VALID),
    .oRQ_DATA      (oRQ_DATA),
    .oLDST_USE     (oLDST_USE),
    .oLDST_REQ     (oLDST_REQ),
    .iLDST_BUSY    (iLDST_BUSY),
    .oLDST_ORDER   (oLDST_ORDER),
    .oLDST_RW      (oLDST_RW),
    .oLDST_ADDR    (oLDST_ADDR),
    .oLDST_DATA    (oLDST_DATA),
    .iLDST_REQ     (iLDST_REQ),
    .iLDST_DATA    (iLDST_DATA),
    .oPROTOCOL_ERR (oPROTOCOL_ERR)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Model: owner index (-1 = nobody), draining flag, outstanding count, sticky error.
  int m_own = -1;
  bit m_drain = 1'b0;
  int m_cnt = 0;
  bit m_err = 1'b0;
  int n_own;
  bit n_drain;
  int n_cnt;
  bit n_err;

  always @(negedge iCLOCK) begin : compare
    logic [2:0]  e_busy;
    logic [2:0]  e_valid;
    logic        e_req;
    logic [31:0] e_data;
    int          acc;
    int          dec;
    e_busy  = 3'b111;
    e_valid = 3'b000;
    e_req   = 1'b0;
    if (m_own >= 0) begin
      if (!m_drain) begin
        e_req = iRQ_REQ[m_own] && (m_cnt < MAXO);
        e_busy[m_own] = iLDST_BUSY || (m_cnt == MAXO);
      end
      if (iLDST_REQ && m_cnt > 0) e_valid[m_own] = 1'b1;
    end
    e_data = (e_valid != 3'b000) ? iLDST_DATA : 32'd0;
    if (inRESET) begin
      chk("m_use",   {31'd0, oLDST_USE}, {31'd0, (m_own >= 0)});
      chk("m_req",   {31'd0, oLDST_REQ}, {31'd0, e_req});
      chk("m_busy",  {29'd0, oRQ_BUSY}, {29'd0, e_busy});
      chk("m_valid", {29'd0, oRQ_VALID}, {29'd0, e_valid});
      chk("m_rdata", oRQ_DATA, e_data);
      chk("m_err",   {31'd0, oPROTOCOL_ERR}, {31'd0, m_err});
      if (m_own >= 0 && !m_drain) begin
        chk("m_addr",  oLDST_ADDR, adr[m_own]);
        chk("m_wdata", oLDST_DATA, wd[m_own]);
        chk("m_order", {30'd0, oLDST_ORDER}, {30'd0, ord[m_own]});
        chk("m_rw",    {31'd0, oLDST_RW}, {31'd0, iRQ_RW[m_own]});
      end else if (m_own < 0) begin
        chk("m_idle_addr", oLDST_ADDR, 32'd0);
      end
    end
    acc     = (e_req && !iLDST_BUSY) ? 1 : 0;
    dec     = (iLDST_REQ && m_cnt > 0) ? 1 : 0;
    n_cnt   = m_cnt + acc - dec;
    n_err   = m_err || (iLDST_REQ && m_cnt == 0);
    n_own   = m_own;
    n_drain = m_drain;
    if (m_own < 0) begin
      if (iRQ_USE != 3'b000) begin
        n_own   = iRQ_USE[0] ? 0 : (iRQ_USE[1] ? 1 : 2);
        n_drain = 1'b0;
      end
    end else if (!m_drain) begin
      if (!iRQ_USE[m_own]) begin
        if (n_cnt == 0) n_own = -1;
        else n_drain = 1'b1;
      end
    end else if (n_cnt == 0) begin
      n_own   = -1;
      n_drain = 1'b0;
    end
  end

  always @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET || iRESET_SYNC) begin
      m_own = -1; m_drain = 1'b0; m_cnt = 0; m_err = 1'b0;
    end else begin
      m_own = n_own; m_drain = n_drain; m_cnt = n_cnt; m_err = n_err;
    end
  end

  task automatic step();
    @(posedge iCLOCK);
    #1;
  endtask

  initial begin
    logic [2:0] use_r;
    inRESET = 1'b0; iRESET_SYNC = 1'b0;
    iRQ_USE = '0; iRQ_REQ = '0; iRQ_RW = '0;
    for (int i = 0; i < 3; i++) begin ord[i] = '0; adr[i] = '0; wd[i] = '0; end
    iLDST_BUSY = 1'b0; iLDST_REQ = 1'b0; iLDST_DATA = '0;
    repeat (3) @(posedge iCLOCK);
    #1 inRESET = 1'b1;

    @(negedge iCLOCK);
    chk("rst_busy", {29'd0, oRQ_BUSY}, 32'd7);
    chk("rst_use", {31'd0, oLDST_USE}, 32'd0);
    chk("rst_valid", {29'd0, oRQ_VALID}, 32'd0);
    chk("rst_err", {31'd0, oPROTOCOL_ERR}, 32'd0);
    step();

    // Simultaneous USE from 0 and 2: port 0 wins, word read, response routed.
    iRQ_USE = 3'b101;
    @(negedge iCLOCK); chk("s1_idle_busy", {29'd0, oRQ_BUSY}, 32'd7); step();
    iRQ_REQ = 3'b001; ord[0] = 2'b10; adr[0] = 32'h0000_1004;
    @(negedge iCLOCK);
    chk("s1_grant_busy", {29'd0, oRQ_BUSY}, 32'h6);
    chk("s1_ldst_addr", oLDST_ADDR, 32'h0000_1004);
    chk("s1_ldst_order", {30'd0, oLDST_ORDER}, 32'd2);
    step();
    iRQ_REQ = 3'b000; iLDST_REQ = 1'b1; iLDST_DATA = 32'hDEAD_BEEF;
    @(negedge iCLOCK);
    chk("s1_valid", {29'd0, oRQ_VALID}, 32'd1);
    chk("s1_rdata", oRQ_DATA, 32'hDEAD_BEEF);
    step();
    iLDST_REQ = 1'b0; iRQ_USE = 3'b100;
    @(negedge iCLOCK); step();
    @(negedge iCLOCK);
    chk("s1_bubble_use", {31'd0, oLDST_USE}, 32'd0);
    step();

    // Owner 2 fills the outstanding window, then one response reopens it.
    iRQ_REQ = 3'b100; ord[2] = 2'b10; adr[2] = 32'h0000_0040;
    @(negedge iCLOCK); chk("s2_owner2_busy", {29'd0, oRQ_BUSY}, 32'h3);
    step();
    repeat (2) begin @(negedge iCLOCK); step(); end
    @(negedge iCLOCK);
    chk("s2_full_req", {31'd0, oLDST_REQ}, 32'd0);
    chk("s2_full_busy", {29'd0, oRQ_BUSY}, 32'd7);
    step();
    iLDST_REQ = 1'b1; iLDST_DATA = 32'h1111_1111;
    @(negedge iCLOCK); chk("s2_valid", {29'd0, oRQ_VALID}, 32'h4); step();
    iLDST_REQ = 1'b0; iRQ_REQ = 3'b000;
    @(negedge iCLOCK); chk("s2_busy_fall", {29'd0, oRQ_BUSY}, 32'h3); step();

    // Release with 2 outstanding: drain delivers both responses to port 2.
    iRQ_USE = 3'b000;
    @(negedge iCLOCK); step();
    iRQ_REQ = 3'b100; iLDST_REQ = 1'b1; iLDST_DATA = 32'h2222_2222;
    @(negedge iCLOCK);
    chk("s3_drain_req", {31'd0, oLDST_REQ}, 32'd0);
    chk("s3_drain_use", {31'd0, oLDST_USE}, 32'd1);
    chk("s3_drain_v1", {29'd0, oRQ_VALID}, 32'h4);
    step();
    iLDST_DATA = 32'h3333_3333;
    @(negedge iCLOCK); chk("s3_drain_v2", oRQ_DATA, 32'h3333_3333); step();
    iLDST_REQ = 1'b0; iRQ_REQ = 3'b000;
    @(negedge iCLOCK); chk("s3_idle_use", {31'd0, oLDST_USE}, 32'd0); step();

    // Accept and response together at count 1 keeps count 1: only two more fit.
    iRQ_USE = 3'b010;
    @(negedge iCLOCK); step();
    iRQ_REQ = 3'b010;
    @(negedge iCLOCK); step();
    iLDST_REQ = 1'b1;
    @(negedge iCLOCK); chk("s4_both_valid", {29'd0, oRQ_VALID}, 32'h2); step();
    iLDST_REQ = 1'b0;
    repeat (2) begin @(negedge iCLOCK); chk("s4_room_req", {31'd0, oLDST_REQ}, 32'd1); step(); end
    @(negedge iCLOCK); chk("s4_full_req", {31'd0, oLDST_REQ}, 32'd0); step();
    iRQ_REQ = 3'b000; iLDST_REQ = 1'b1;
    repeat (3) begin @(negedge iCLOCK); step(); end
    iLDST_REQ = 1'b0;

    // Port 1 write held off by iLDST_BUSY for 4 cycles.
    iRQ_REQ = 3'b010; iRQ_RW = 3'b010; ord[1] = 2'b10; adr[1] = 32'h20; wd[1] = 32'h55AA_55AA;
    iLDST_BUSY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge iCLOCK);
      chk("s5_hold_addr", oLDST_ADDR, 32'h20);
      chk("s5_hold_data", oLDST_DATA, 32'h55AA_55AA);
      chk("s5_hold_busy", {29'd0, oRQ_BUSY}, 32'd7);
      step();
    end
    iLDST_BUSY = 1'b0;
    @(negedge iCLOCK);
    chk("s5_go_busy", {29'd0, oRQ_BUSY}, 32'h5);
    chk("s5_go_rw", {31'd0, oLDST_RW}, 32'd1);
    step();
    iRQ_REQ = 3'b000; iRQ_RW = 3'b000; iLDST_REQ = 1'b1;
    @(negedge iCLOCK); step();

    // Response with nothing outstanding: not forwarded, error sticks.
    @(negedge iCLOCK);
    chk("s6_unfwd", {29'd0, oRQ_VALID}, 32'd0);
    chk("s6_err_pre", {31'd0, oPROTOCOL_ERR}, 32'd0);
    step();
    iLDST_REQ = 1'b0;
    @(negedge iCLOCK); chk("s6_err_set", {31'd0, oPROTOCOL_ERR}, 32'd1); step();
    @(negedge iCLOCK); chk("s6_err_hold", {31'd0, oPROTOCOL_ERR}, 32'd1); step();

    // Asynchronous reset mid-OWNED takes effect without a clock edge.
    iRQ_REQ = 3'b010;
    #2;
    chk("s6_pre_rst_req", {31'd0, oLDST_REQ}, 32'd1);
    inRESET = 1'b0;
    #1;
    chk("s6_arst_busy", {29'd0, oRQ_BUSY}, 32'd7);
    chk("s6_arst_use", {31'd0, oLDST_USE}, 32'd0);
    chk("s6_arst_req", {31'd0, oLDST_REQ}, 32'd0);
    chk("s6_arst_err", {31'd0, oPROTOCOL_ERR}, 32'd0);
    iRQ_USE = 3'b000; iRQ_REQ = 3'b000;
    @(posedge iCLOCK); #1 inRESET = 1'b1;

    // Synchronous reset drops ownership at the next edge.
    iRQ_USE = 3'b001;
    @(negedge iCLOCK); step();
    iRQ_REQ = 3'b001; iRESET_SYNC = 1'b1;
    @(negedge iCLOCK); step();
    iRESET_SYNC = 1'b0; iRQ_USE = 3'b000; iRQ_REQ = 3'b000;
    @(negedge iCLOCK); chk("s7_srst_use", {31'd0, oLDST_USE}, 32'd0); step();

    // Random bursts from all three requesters.
    use_r = 3'b000;
    repeat (3000) begin
      for (int i = 0; i < 3; i++) begin
        if (use_r[i]) begin
          if ($urandom_range(0, 15) == 0) use_r[i] = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
          use_r[i] = 1'b1;
        end
        iRQ_REQ[i] = use_r[i] && ($urandom_range(0, 1) == 1);
        iRQ_RW[i]  = 1'($urandom_range(0, 1));
        ord[i]     = 2'($urandom_range(0, 3));
        adr[i]     = $urandom;
        wd[i]      = $urandom;
      end
      iRQ_USE     = use_r;
      iLDST_BUSY  = ($urandom_range(0, 3) == 0);
      iLDST_REQ   = (m_cnt > 0) && ($urandom_range(0, 2) != 0);
      iLDST_DATA  = $urandom;
      iRESET_SYNC = ($urandom_range(0, 299) == 0);
      step();
    end
    iRQ_USE = '0; iRQ_REQ = '0; iLDST_REQ = 1'b0; iRESET_SYNC = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_control_ldst_arbiter.md
Name: pipeline_control_ldst_arbiter

Overview:
- Shares the single core load/store port between three requesters:
  - port 0: interrupt-handler IDT read, highest priority
  - port 1: exception/sysreg save-restore sequencer
  - port 2: execution-stage LSU, lowest priority
- Grants ownership per transaction burst, based on requester USE.
- Muxes the owner's request onto the load/store unit and routes responses back to the owner.
- Tracks outstanding accesses so ownership never changes while a response is pending.

Parameters:
- P_MAX_OUTSTANDING, 3: maximum accepted-but-unanswered accesses for the current owner (1..3).

Ports:
- iCLOCK  in  1  core clock
- inRESET  in  1  asynchronous active-low reset
- iRESET_SYNC  in  1  synchronous reset, same effect as inRESET
- iRQ_USE  in  3  per-requester ownership request, held for the whole burst
- iRQ_REQ  in  3  per-requester access strobe
- iRQ_ORDER  in  6  2 bits per requester: 00 byte, 01 2-byte, 10 word, 11 none
- iRQ_RW  in  3  per-requester direction: 0 read, 1 write
- iRQ_ADDR  in  96  32 bits per requester, requester n at [32n+31:32n]
- iRQ_DATA  in  96  32 bits per requester, write data
- oRQ_BUSY  out  3  per-requester stall
- oRQ_VALID  out  3  per-requester response strobe
- oRQ_DATA  out  32  response data (shared)
- oLDST_USE  out  1  port owned
- oLDST_REQ  out  1  access strobe to load/store unit
- iLDST_BUSY  in  1  load/store unit cannot accept
- oLDST_ORDER  out  2  owner order
- oLDST_RW  out  1  owner direction
- oLDST_ADDR  out  32  owner address
- oLDST_DATA  out  32  owner write data
- iLDST_REQ  in  1  response strobe (reads and writes both answered)
- iLDST_DATA  in  32  response data
- oPROTOCOL_ERR  out  1  sticky: response received with zero outstanding

Behaviour:
- State machine with three states: IDLE, OWNED, DRAIN. Registers: 2-bit owner index b_owner, 2-bit counter b_outstd.
- Reset values (inRESET low or iRESET_SYNC high):
  - state IDLE, b_owner 0, b_outstd 0
  - oRQ_BUSY 3'b111, oRQ_VALID 0, oRQ_DATA 0, oPROTOCOL_ERR 0
  - all oLDST_* outputs 0
- IDLE:
  - oLDST_* driven 0; every requester sees BUSY=1.
  - If any iRQ_USE is set, the lowest-index set bit becomes b_owner and the state goes to OWNED next cycle.
  - Arbitration latency is 1 cycle from USE to the owner's BUSY being able to fall.
- OWNED:
  - oLDST_USE=1.
  - oLDST_REQ/ORDER/RW/ADDR/DATA are combinational copies of the owner's slice.
  - oLDST_REQ is forced 0 while b_outstd==P_MAX_OUTSTANDING.
  - oRQ_BUSY[owner] = iLDST_BUSY | (b_outstd==P_MAX_OUTSTANDING); non-owners see BUSY=1.
  - An access is accepted when oLDST_REQ && !iLDST_BUSY.
  - No preemption: a higher-priority USE waits until the owner releases.
- Counter:
  - +1 on accept, -1 on iLDST_REQ; both in the same cycle leaves it unchanged.
  - It never wraps.
  - iLDST_REQ with b_outstd==0 sets oPROTOCOL_ERR, is not forwarded, and the count stays 0.
- Response routing:
  - oRQ_VALID[b_owner] = iLDST_REQ in OWNED or DRAIN (combinational, same cycle).
  - oRQ_DATA = iLDST_DATA when any VALID is set, else 0.
- Release:
  - When iRQ_USE[owner] falls: if b_outstd==0, or it is 1 with a response this cycle, go to IDLE; otherwise go to DRAIN.
  - DRAIN: oLDST_REQ=0, oLDST_USE=1, all BUSY=1, responses still routed. Go to IDLE the cycle the count reaches 0.
  - Re-grant happens from IDLE, so there is a 1-cycle bubble minimum between owners.
- An owner reasserting USE during DRAIN is treated as a new arbitration after IDLE.
- Reset mid-burst: pending responses are discarded. The load/store unit is reset by the same sync reset.

Decomposition:
- Package pipeline_control_ldst_arb_pkg holds:
  - the state enum (IDLE/OWNED/DRAIN)
  - requester index constants (HUNDLER=0, SYSREG=1, LSU=2)
  - ORDER encodings and the RW encoding
- One sub-module, pipeline_control_ldst_arb_outstd: saturating up/down outstanding counter with full, empty and underflow-error outputs.

Test Plan:
- USE=3'b101 in the same cycle → owner 0 granted; BUSY=3'b110 next cycle. Port 0 word read at 0x0000_1004, response 0xDEAD_BEEF → oRQ_VALID=3'b001, oRQ_DATA=0xDEAD_BEEF. Port 0 drops USE → IDLE, then owner 2 one cycle later.
- Owner 2 issues 3 reads with iLDST_BUSY=0 and no responses → count 3, oLDST_REQ held 0, BUSY[2]=1. One response → count 2, BUSY[2] falls.
- Owner drops USE with 2 outstanding → DRAIN: oLDST_REQ=0, VALID pulses twice to the old owner, then IDLE.
- Accept and response in the same cycle at count 1 → count stays 1.
- iLDST_BUSY=1 for 4 cycles during a port-1 write to 0x20 with data 0x55AA_55AA → oLDST outputs stable, BUSY[1]=1, accepted on the 5th cycle.
- iLDST_REQ with count 0 → oPROTOCOL_ERR=1 and stays 1 until reset. Async reset mid-OWNED → all outputs at reset values immediately.
